tx_fifo_arbiter: RTL and testbench

Frame-granular round-robin arbiter that shares the write port of the TX async FIFO between two byte-stream requesters (e.g. ARP responder and UDP builder). It lives entirely in the FIFO write clock domain. It grants one requester per frame and streams that requester's bytes into the FIFO as {last, data} words, stalling on full. It enforces a maximum frame length and a minimum idle gap between frames.

---
 rtl/eth_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 16 +
 rtl/tx_fifo_arbiter.sv | 168 ++++++++++++++++
 tb/tb_tx_fifo_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants for the Ethernet TX path: default widths, frame limits and the
// arbiter FSM state encodings.
package eth_pkg;

  localparam int unsigned DSIZE_DEF   = 8;
  localparam int unsigned MAX_LEN_DEF = 1518;
  localparam int unsigned IFG_DEF     = 2;

  // Arbiter FSM encodings, kept as plain constants for legacy tools.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StXfer = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;
  localparam logic [1:0] StGap  = 2'd3;

  // The last flag sits just above the data byte in each FIFO word.
  function automatic int unsigned last_bit(input int unsigned dsize);
    return dsize;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: one-hot pick among the asserted valids,
// with ptr choosing the winner when both are asserted.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] pick
);

  always_comb begin
    pick = valid;
    if (valid == 2'b11) begin
      pick = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/tx_fifo_arbiter.sv
// Frame-granular round-robin arbiter feeding the TX async FIFO write port from two
// byte-stream requesters, with overlength truncation and an inter-frame gap.
module tx_fifo_arbiter
  import eth_pkg::*;
#(
  parameter int unsigned DSIZE   = DSIZE_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned IFG     = IFG_DEF
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [DSIZE-1:0] s0_data,
  input  logic             s0_last,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [DSIZE-1:0] s1_data,
  input  logic             s1_last,
  output logic             winc,
  output logic [DSIZE:0]   wdata,
  input  logic             wfull,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [1:0]       ovl_err,
  input  logic             clr_err,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned LW      = $clog2(MAX_LEN + 1);
  localparam int unsigned GW      = (IFG > 1) ? $clog2(IFG) : 1;
  localparam int unsigned LastIdx = last_bit(DSIZE);
  localparam logic [LW-1:0] LenLast = LW'(MAX_LEN - 1);
  localparam logic [GW-1:0] GapLast = GW'(IFG - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       ovl_q, ovl_d;
  logic             rr_q, rr_d;
  logic [LW-1:0]    len_q, len_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [1:0]       pick;
  logic             sel;
  logic             sel_valid;
  logic             sel_last;
  logic [DSIZE-1:0] sel_data;
  logic             at_max;
  logic             last_out;
  logic             xfer;
  logic             take;

  rr_pick2 u_rr_pick2 (
    .valid ({s1_valid, s0_valid}),
    .ptr   (rr_q),
    .pick  (pick)
  );

  assign sel       = grant_q[1];
  assign sel_valid = sel ? s1_valid : s0_valid;
  assign sel_last  = sel ? s1_last  : s0_last;
  assign sel_data  = sel ? s1_data  : s0_data;
  assign at_max    = (len_q == LenLast);
  assign last_out  = sel_last | at_max;

  // DROP drains the requester regardless of FIFO state since nothing is written.
  assign take     = ((state_q == StXfer) & ~wfull) | (state_q == StDrop);
  assign s0_ready = take & grant_q[0];
  assign s1_ready = take & grant_q[1];
  assign xfer     = (state_q == StXfer) & sel_valid & ~wfull;

  assign winc                = xfer;
  assign wdata[LastIdx]      = last_out;
  assign wdata[DSIZE-1:0]    = sel_data;
  assign grant               = grant_q;
  assign busy                = (state_q != StIdle);
  assign ovl_err             = ovl_q;
  assign frame_cnt           = cnt_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    len_d   = len_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    ovl_d   = clr_err ? 2'b00 : ovl_q;

    unique case (state_q)
      StIdle: begin
        if (|pick) begin
          grant_d = pick;
          len_d   = '0;
          state_d = StXfer;
        end
      end

      StXfer: begin
        if (xfer) begin
          len_d = len_q + LW'(1);
          if (last_out) begin
            cnt_d = cnt_q + 16'd1;
            rr_d  = ~sel;
            gap_d = '0;
            if (!sel_last) begin
              // Truncated frame: the rest of the requester's bytes are discarded.
              ovl_d[sel] = 1'b1;
              state_d    = StDrop;
            end else if (IFG == 0) begin
              grant_d = 2'b00;
              state_d = StIdle;
            end else begin
              state_d = StGap;
            end
          end
        end
      end

      StDrop: begin
        if (sel_valid && sel_last) begin
          gap_d = '0;
          if (IFG == 0) begin
            grant_d = 2'b00;
            state_d = StIdle;
          end else begin
            state_d = StGap;
          end
        end
      end

      StGap: begin
        if (gap_q == GapLast) begin
          grant_d = 2'b00;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        grant_d = 2'b00;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      ovl_q   <= 2'b00;
      rr_q    <= 1'b0;
      len_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ovl_q   <= ovl_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Self-checking bench for tx_fifo_arbiter: per-requester frame queues, a word-level
// expected FIFO stream per requester, and scenario tasks run in sequence.
module tb_tx_fifo_arbiter;

  localparam int unsigned DSIZE   = 8;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned IFG     = 2;

  logic             wclk = 1'b0;
  logic             wrst_n = 1'b1;
  logic             s0_valid = 1'b0, s1_valid = 1'b0;
  logic             s0_last = 1'b0, s1_last = 1'b0;
  logic [DSIZE-1:0] s0_data = '0, s1_data = '0;
  logic             s0_ready, s1_ready;
  logic             winc;
  logic [DSIZE:0]   wdata;
  logic             wfull = 1'b0;
  logic [1:0]       grant;
  logic             busy;
  logic [1:0]       ovl_err;
  logic             clr_err = 1'b0;
  logic [15:0]      frame_cnt;

  tx_fifo_arbiter #(.DSIZE(DSIZE), .MAX_LEN(MAX_LEN), .IFG(IFG)) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data), .s0_last(s0_last),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data), .s1_last(s1_last),
    .winc(winc), .wdata(wdata), .wfull(wfull), .grant(grant), .busy(busy),
    .ovl_err(ovl_err), .clr_err(clr_err), .frame_cnt(frame_cnt)
  );

  always #5 wclk = ~wclk;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] src0[$], src1[$], exp0[$], exp1[$];
  int         order[$];
  int         exp_frames = 0;
  int         valid_pct = 100, full_pct = 0;
  bit         full_force = 0, clr_on_last = 0, clr_this = 0;
  bit         hs0 = 0, hs1 = 0, in_frame = 0;
  logic       s_winc, s_rdy0;
  int         n_winc = 0, n_drop = 0, grant0_cycles = 0;
  int         cyc = 0, last_end = 0, last_spacing = 0;

  // Model: a frame of len bytes yields min(len, MAX_LEN) words, last flag on the final one.
  task automatic add_frame(input int req, input int len, input bit seq, input logic [7:0] base);
    logic [7:0] d;
    logic       lst, wl;
    for (int i = 0; i < len; i++) begin
      d   = seq ? base + 8'(i) : 8'($urandom);
      lst = (i == len - 1);
      wl  = lst || (i == int'(MAX_LEN) - 1);
      if (req == 0) src0.push_back({lst, d}); else src1.push_back({lst, d});
      if (i < int'(MAX_LEN)) begin
        if (req == 0) exp0.push_back({wl, d}); else exp1.push_back({wl, d});
      end
    end
    exp_frames++;
  endtask

  task automatic drive();
    if (hs0) void'(src0.pop_front());
    if (hs1) void'(src1.pop_front());
    if (!s0_valid || hs0) begin
      if (src0.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
        s0_valid = 1'b1;
        {s0_last, s0_data} = src0[0];
      end else s0_valid = 1'b0;
    end
    if (!s1_valid || hs1) begin
      if (src1.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
        s1_valid = 1'b1;
        {s1_last, s1_data} = src1[0];
      end else s1_valid = 1'b0;
    end
    wfull = full_force || (int'($urandom_range(99)) < full_pct);
  endtask

  task automatic step();
    int         owner;
    logic [8:0] expw;
    logic [1:0] exp_g;
    @(negedge wclk);
    cyc++;
    hs0    = s0_valid && s0_ready;
    hs1    = s1_valid && s1_ready;
    s_winc = winc;
    s_rdy0 = s0_ready;
    if (grant == 2'b01) grant0_cycles++;
    if (winc) begin
      n_winc++;
      n_vec++;
      if (wfull) begin
        n_err++;
        $display("FAIL winc_full: winc=1 with wfull=1 at %0t", $time);
      end
      n_vec++;
      if (hs0 == hs1) begin
        n_err++;
        $display("FAIL write_owner: hs0=%0b hs1=%0b, required exactly one", hs0, hs1);
      end else begin
        owner = hs1 ? 1 : 0;
        exp_g = hs1 ? 2'b10 : 2'b01;
        n_vec++;
        if (grant !== exp_g) begin
          n_err++;
          $display("FAIL grant_owner: grant=%b, required %b", grant, exp_g);
        end
        if (!in_frame) begin
          order.push_back(owner);
          last_spacing = cyc - last_end;
          in_frame = 1;
        end
        if (wdata[8]) begin
          in_frame = 0;
          last_end = cyc;
          if (clr_on_last && hs0) begin
            clr_err     = 1'b1;
            clr_on_last = 0;
            clr_this    = 1;
          end
        end
        n_vec++;
        if ((owner == 0 && exp0.size() == 0) || (owner == 1 && exp1.size() == 0)) begin
          n_err++;
          $display("FAIL unexpected_word: wdata=%h from s%0d, required no write", wdata, owner);
        end else begin
          expw = (owner == 1) ? exp1.pop_front() : exp0.pop_front();
          if (wdata !== expw) begin
            n_err++;
            $display("FAIL wdata: got %h, required %h (s%0d)", wdata, expw, owner);
          end
        end
      end
    end else if (hs0 || hs1) n_drop++;
    @(posedge wclk);
    #1;
    if (clr_this) begin
      clr_err  = 1'b0;
      clr_this = 0;
    end
    drive();
  endtask

  task automatic drain();
    int n = 0;
    do begin
      step();
      n++;
    end while ((src0.size() > 0 || src1.size() > 0 || busy || s0_valid || s1_valid) && n < 3000);
    n_vec++;
    if (n >= 3000 || exp0.size() != 0 || exp1.size() != 0) begin
      n_err++;
      $display("FAIL drain: cycles=%0d left exp0=%0d exp1=%0d, required all delivered",
               n, exp0.size(), exp1.size());
    end
  endtask

  task automatic flush();
    s0_valid = 0; s1_valid = 0; wfull = 0; clr_err = 0; full_force = 0;
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete(); order.delete();
    hs0 = 0; hs1 = 0; in_frame = 0; exp_frames = 0;
  endtask

  task automatic do_reset();
    flush();
    wrst_n = 1'b0;
    repeat (2) @(posedge wclk);
    #1 wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 wrst_n = 1'b0;
    #3;
    n_vec++;
    if ({grant, busy, s0_ready, s1_ready, winc} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl: {grant,busy,rdy0,rdy1,winc}=%b, required 000000",
               {grant, busy, s0_ready, s1_ready, winc});
    end
    n_vec++;
    if ({ovl_err, frame_cnt} !== 18'b0) begin
      n_err++;
      $display("FAIL reset_stat: ovl=%b frame_cnt=%0d, required 0/0", ovl_err, frame_cnt);
    end
    repeat (2) @(posedge wclk);
    #1 wrst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    n_winc = 0; grant0_cycles = 0;
    add_frame(0, 5, 1, 8'h01);
    drain();
    n_vec++;
    if (n_winc != 5) begin n_err++; $display("FAIL single_winc: %0d, required 5", n_winc); end
    n_vec++;
    if (frame_cnt !== 16'd1) begin
      n_err++; $display("FAIL single_cnt: %0d, required 1", frame_cnt);
    end
    n_vec++;
    if (grant0_cycles != 5 + int'(IFG)) begin
      n_err++; $display("FAIL single_grant_len: %0d, required %0d", grant0_cycles, 5 + IFG);
    end
  endtask

  task automatic test_contention();
    do_reset();
    add_frame(0, 3, 1, 8'h10); add_frame(1, 3, 1, 8'h20);
    add_frame(0, 3, 1, 8'h30); add_frame(1, 3, 1, 8'h40);
    drain();
    n_vec++;
    if (order.size() != 4) begin
      n_err++; $display("FAIL rr_frames: %0d frames, required 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (order[i] != i % 2) begin
          n_err++; $display("FAIL rr_order[%0d]: s%0d, required s%0d", i, order[i], i % 2);
        end
      end
    end
    n_vec++;
    if (frame_cnt !== 16'd4) begin n_err++; $display("FAIL rr_cnt: %0d, required 4", frame_cnt); end
  endtask

  task automatic test_backpressure();
    n_winc = 0;
    add_frame(0, 7, 1, 8'h40);
    repeat (3) step();
    full_force = 1; wfull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) full_force = 0;
      step();
      n_vec++;
      if (s_winc !== 1'b0 || s_rdy0 !== 1'b0) begin
        n_err++; $display("FAIL stall[%0d]: winc=%b ready=%b, required 0/0", i, s_winc, s_rdy0);
      end
    end
    drain();
    n_vec++;
    if (n_winc != 7) begin n_err++; $display("FAIL bp_winc: %0d, required 7", n_winc); end
  endtask

  task automatic test_overlength();
    n_winc = 0; n_drop = 0;
    add_frame(1, 12, 1, 8'h80);
    drain();
    n_vec++;
    if (n_winc != 8 || n_drop != 4) begin
      n_err++; $display("FAIL ovl_split: writes=%0d drops=%0d, required 8/4", n_winc, n_drop);
    end
    n_vec++;
    if (ovl_err !== 2'b10) begin n_err++; $display("FAIL ovl_set: %b, required 10", ovl_err); end
    clr_err = 1'b1; step(); clr_err = 1'b0;
    n_vec++;
    if (ovl_err !== 2'b00) begin n_err++; $display("FAIL ovl_clr: %b, required 00", ovl_err); end
    clr_on_last = 1;
    add_frame(0, 12, 1, 8'hA0);
    drain();
    n_vec++;
    if (ovl_err !== 2'b01) begin
      n_err++; $display("FAIL ovl_set_wins: %b, required 01", ovl_err);
    end
    clr_err = 1'b1; step(); clr_err = 1'b0;
  endtask

  task automatic test_exact_max();
    n_winc = 0; n_drop = 0;
    add_frame(0, 8, 1, 8'hC0);
    add_frame(1, 3, 1, 8'hD0);
    drain();
    n_vec++;
    if (n_winc != 11 || n_drop != 0 || ovl_err !== 2'b00) begin
      n_err++;
      $display("FAIL exact_max: writes=%0d drops=%0d ovl=%b, required 11/0/00",
               n_winc, n_drop, ovl_err);
    end
    n_vec++;
    if (last_spacing != int'(IFG) + 2) begin
      n_err++; $display("FAIL frame_gap: %0d cycles, required %0d", last_spacing, IFG + 2);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    n_winc = 0;
    add_frame(0, 6, 1, 8'hE0);
    while (n_winc < 3 && n < 100) begin step(); n++; end
    wrst_n = 1'b0;
    #2;
    n_vec++;
    if ({grant, busy, s0_ready, s1_ready, winc, ovl_err, frame_cnt} !== 24'b0) begin
      n_err++;
      $display("FAIL mid_reset: grant=%b busy=%b rdy=%b%b winc=%b ovl=%b cnt=%0d, required 0",
               grant, busy, s0_ready, s1_ready, winc, ovl_err, frame_cnt);
    end
    flush();
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    add_frame(1, 2, 1, 8'h50);
    add_frame(0, 2, 1, 8'h60);
    drain();
    n_vec++;
    if (order.size() != 2 || order[0] != 0 || frame_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL post_reset: frames=%0d first=s%0d cnt=%0d, required 2/s0/2",
               order.size(), (order.size() > 0) ? order[0] : -1, frame_cnt);
    end
  endtask

  task automatic test_random();
    logic [1:0] want_ovl = 2'b00;
    int         req, len;
    valid_pct = 70; full_pct = 25;
    for (int i = 0; i < 16; i++) begin
      req = int'($urandom_range(1));
      len = int'($urandom_range(12, 1));
      if (len > int'(MAX_LEN)) want_ovl[req] = 1'b1;
      add_frame(req, len, 0, 8'h00);
    end
    drain();
    n_vec++;
    if (frame_cnt !== 16'(exp_frames)) begin
      n_err++; $display("FAIL rand_cnt: %0d, required %0d", frame_cnt, exp_frames);
    end
    n_vec++;
    if (ovl_err !== want_ovl) begin
      n_err++; $display("FAIL rand_ovl: %b, required %b", ovl_err, want_ovl);
    end
    valid_pct = 100; full_pct = 0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_contention();
    test_backpressure();
    test_overlength();
    test_exact_max();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
